// File: rtl/id_stage_hazard.sv
// Decode stage: register bank, immediates, early branch/jump resolution, hazard stall FSM and ID/EX register.
// Optional macro ID_PERF_COUNTERS_EN adds saturating stall-cycle and redirect counters.
module id_stage_hazard #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int PC_SIZE             = 32,
    parameter int BUS_SIZE            = 32,
    parameter int CTRL_SIZE           = 16,
    localparam int AW                 = $clog2(REGISTERS_BANK_SIZE)
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic                                   i_valid,
    input  logic [BUS_SIZE-1:0]                    i_instruction,
    input  logic [PC_SIZE-1:0]                     i_next_seq_pc,
    input  logic                                   i_wb_write_enable,
    input  logic [AW-1:0]                          i_wb_addr,
    input  logic [BUS_SIZE-1:0]                    i_wb_data,
    input  logic                                   i_ex_wb,
    input  logic                                   i_ex_mem_read,
    input  logic [AW-1:0]                          i_ex_dst,
    input  logic                                   i_mem_wb,
    input  logic [AW-1:0]                          i_mem_dst,
    input  logic [BUS_SIZE-1:0]                    i_mem_data,
    input  logic                                   i_ex_ready,
    input  logic                                   i_flush,
    output logic                                   o_stall,
    output logic                                   o_redirect,
    output logic [PC_SIZE-1:0]                     o_redirect_pc,
    output logic                                   o_valid,
    output logic [CTRL_SIZE-1:0]                   o_ctrl,
    output logic [BUS_SIZE-1:0]                    o_bus_a,
    output logic [BUS_SIZE-1:0]                    o_bus_b,
    output logic [4:0]                             o_rs,
    output logic [4:0]                             o_rt,
    output logic [4:0]                             o_rd,
    output logic [BUS_SIZE-1:0]                    o_inm_ext_signed,
    output logic [BUS_SIZE-1:0]                    o_inm_ext_unsigned,
    output logic [BUS_SIZE-1:0]                    o_shamt_ext,
`ifdef ID_PERF_COUNTERS_EN
    output logic [31:0]                            o_stall_cycles,
    output logic [31:0]                            o_redirects,
`endif
    output logic [REGISTERS_BANK_SIZE*BUS_SIZE-1:0] o_bus_debug
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    localparam int CB_REG_WRITE = 0;
    localparam int CB_REG_DST   = 1;
    localparam int CB_ALU_SRC   = 2;
    localparam int CB_MEM_READ  = 3;
    localparam int CB_MEM_WRITE = 4;
    localparam int CB_MEM_TO_REG = 5;
    localparam int CB_BRANCH    = 6;
    localparam int CB_JUMP      = 7;
    localparam int CB_LINK      = 8;
    localparam int CB_IMM_UNS   = 9;
    localparam int CB_SHAMT     = 10;

    typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

    // Control vector handed to EX; [13:11] selects the ALU operation class.
    function automatic logic [15:0] main_control(input logic [5:0] op, input logic [5:0] funct);
        logic [15:0] c;
        c = 16'h0000;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    c[CB_JUMP] = 1'b1;
                end else if (funct == FN_JALR) begin
                    c[CB_JUMP]      = 1'b1;
                    c[CB_LINK]      = 1'b1;
                    c[CB_REG_WRITE] = 1'b1;
                    c[CB_REG_DST]   = 1'b1;
                end else begin
                    c[CB_REG_WRITE] = 1'b1;
                    c[CB_REG_DST]   = 1'b1;
                    c[CB_SHAMT]     = (funct[5:2] == 4'b0000);
                    c[13:11]        = 3'd1;
                end
            end
            OP_J:    c[CB_JUMP] = 1'b1;
            OP_JAL:  begin c[CB_JUMP] = 1'b1; c[CB_LINK] = 1'b1; c[CB_REG_WRITE] = 1'b1; end
            OP_BEQ,
            OP_BNE:  begin c[CB_BRANCH] = 1'b1; c[13:11] = 3'd5; end
            OP_ADDI: begin c[CB_REG_WRITE] = 1'b1; c[CB_ALU_SRC] = 1'b1; end
            OP_ANDI: begin c[CB_REG_WRITE] = 1'b1; c[CB_ALU_SRC] = 1'b1; c[CB_IMM_UNS] = 1'b1; c[13:11] = 3'd2; end
            OP_ORI:  begin c[CB_REG_WRITE] = 1'b1; c[CB_ALU_SRC] = 1'b1; c[CB_IMM_UNS] = 1'b1; c[13:11] = 3'd3; end
            OP_LUI:  begin c[CB_REG_WRITE] = 1'b1; c[CB_ALU_SRC] = 1'b1; c[13:11] = 3'd4; end
            OP_LW:   begin c[CB_REG_WRITE] = 1'b1; c[CB_ALU_SRC] = 1'b1; c[CB_MEM_READ] = 1'b1; c[CB_MEM_TO_REG] = 1'b1; end
            OP_SW:   begin c[CB_ALU_SRC] = 1'b1; c[CB_MEM_WRITE] = 1'b1; end
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    logic [BUS_SIZE-1:0] regs_q [REGISTERS_BANK_SIZE];
    logic [BUS_SIZE-1:0] regs_d [REGISTERS_BANK_SIZE];
    state_t              state_q, state_d;
    logic [1:0]          stall_cnt_q, stall_cnt_d;

    logic                valid_q, valid_d;
    logic [CTRL_SIZE-1:0] ctrl_q, ctrl_d;
    logic [BUS_SIZE-1:0] bus_a_q, bus_a_d, bus_b_q, bus_b_d;
    logic [4:0]          rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [BUS_SIZE-1:0] sext_q, sext_d, zext_q, zext_d, shamt_q, shamt_d;

    logic [5:0]          op_s, funct_s;
    logic [4:0]          rs_f_s, rt_f_s, rd_f_s, shamt_f_s;
    logic [15:0]         imm_s;
    logic [25:0]         dir_s;
    logic [AW-1:0]       rs_a_s, rt_a_s;
    logic [BUS_SIZE-1:0] rd_a_s, rd_b_s, fwd_a_s, fwd_b_s;
    logic                is_branch_s, is_jr_s, is_jump_s, taken_s;
    logic                hits_rs_s, hits_rt_s, h_load_s, h_br_s, hazard_s;
    logic [1:0]          stall_len_s;
    logic [CTRL_SIZE+15:0] ctrl_wide_s;
    logic [PC_SIZE+17:0] br_off_s;
    logic                stall_s, redirect_s, load_s, bubble_s;
    logic [PC_SIZE-1:0]  redirect_pc_s;

    assign op_s      = i_instruction[31:26];
    assign rs_f_s    = i_instruction[25:21];
    assign rt_f_s    = i_instruction[20:16];
    assign rd_f_s    = i_instruction[15:11];
    assign shamt_f_s = i_instruction[10:6];
    assign funct_s   = i_instruction[5:0];
    assign imm_s     = i_instruction[15:0];
    assign dir_s     = i_instruction[25:0];
    assign rs_a_s    = AW'(rs_f_s);
    assign rt_a_s    = AW'(rt_f_s);

    // Write-through reads: a same-cycle WB to the read address wins over the stored value.
    assign rd_a_s  = (rs_a_s == '0) ? '0 :
                     (i_wb_write_enable && (i_wb_addr == rs_a_s)) ? i_wb_data : regs_q[rs_a_s];
    assign rd_b_s  = (rt_a_s == '0) ? '0 :
                     (i_wb_write_enable && (i_wb_addr == rt_a_s)) ? i_wb_data : regs_q[rt_a_s];
    assign fwd_a_s = ((rs_a_s != '0) && i_mem_wb && (i_mem_dst == rs_a_s)) ? i_mem_data : rd_a_s;
    assign fwd_b_s = ((rt_a_s != '0) && i_mem_wb && (i_mem_dst == rt_a_s)) ? i_mem_data : rd_b_s;

    assign is_branch_s = (op_s == OP_BEQ) || (op_s == OP_BNE);
    assign is_jr_s     = (op_s == OP_RTYPE) && ((funct_s == FN_JR) || (funct_s == FN_JALR));
    assign is_jump_s   = (op_s == OP_J) || (op_s == OP_JAL) || is_jr_s;
    assign taken_s     = ((op_s == OP_BEQ) && (fwd_a_s == fwd_b_s)) ||
                         ((op_s == OP_BNE) && (fwd_a_s != fwd_b_s));

    assign hits_rs_s   = (i_ex_dst != '0) && (i_ex_dst == rs_a_s);
    assign hits_rt_s   = (i_ex_dst != '0) && (i_ex_dst == rt_a_s);
    assign h_load_s    = i_ex_mem_read && (hits_rs_s || hits_rt_s);
    assign h_br_s      = i_ex_wb && !i_ex_mem_read &&
                         ((is_branch_s && (hits_rs_s || hits_rt_s)) || (is_jr_s && hits_rs_s));
    assign hazard_s    = i_valid && (h_load_s || h_br_s);
    assign stall_len_s = (h_load_s && (is_branch_s || is_jr_s)) ? 2'd2 : 2'd1;

    assign ctrl_wide_s = {{CTRL_SIZE{1'b0}}, main_control(op_s, funct_s)};
    assign br_off_s    = {{PC_SIZE{imm_s[15]}}, imm_s, 2'b00};

    // Redirect target selection for jumps, register jumps and branches.
    always_comb begin
        redirect_pc_s = i_next_seq_pc + br_off_s[PC_SIZE-1:0];
        if (is_jr_s) begin
            redirect_pc_s = PC_SIZE'(fwd_a_s);
        end else if ((op_s == OP_J) || (op_s == OP_JAL)) begin
            redirect_pc_s = {i_next_seq_pc[PC_SIZE-1:28], dir_s, 2'b00};
        end else begin
            redirect_pc_s = i_next_seq_pc + br_off_s[PC_SIZE-1:0];
        end
    end

    // Stall FSM: flush beats backpressure, backpressure freezes everything.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        stall_s     = 1'b0;
        redirect_s  = 1'b0;
        load_s      = 1'b0;
        bubble_s    = 1'b0;
        if (i_flush) begin
            state_d     = ST_RUN;
            stall_cnt_d = 2'd0;
            bubble_s    = 1'b1;
        end else if (!i_ex_ready) begin
            stall_s = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard_s) begin
                        stall_s     = 1'b1;
                        bubble_s    = 1'b1;
                        stall_cnt_d = stall_len_s - 2'd1;
                        state_d     = (stall_len_s == 2'd2) ? ST_STALL : ST_RUN;
                    end else if (i_valid) begin
                        load_s     = 1'b1;
                        redirect_s = is_jump_s || taken_s;
                    end else begin
                        bubble_s = 1'b1;
                    end
                end
                ST_STALL: begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    if (stall_cnt_q <= 2'd1) begin
                        stall_cnt_d = 2'd0;
                        state_d     = ST_RUN;
                    end else begin
                        stall_cnt_d = stall_cnt_q - 2'd1;
                        state_d     = ST_STALL;
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    stall_cnt_d = 2'd0;
                    bubble_s    = 1'b1;
                end
            endcase
        end
    end

    assign o_stall       = stall_s;
    assign o_redirect    = redirect_s;
    assign o_redirect_pc = redirect_pc_s;

    // ID/EX next value: bubble, load or hold.
    always_comb begin
        valid_d = valid_q; ctrl_d = ctrl_q; bus_a_d = bus_a_q; bus_b_d = bus_b_q;
        rs_d = rs_q; rt_d = rt_q; rd_d = rd_q;
        sext_d = sext_q; zext_d = zext_q; shamt_d = shamt_q;
        if (bubble_s) begin
            valid_d = 1'b0; ctrl_d = '0; bus_a_d = '0; bus_b_d = '0;
            rs_d = 5'd0; rt_d = 5'd0; rd_d = 5'd0;
            sext_d = '0; zext_d = '0; shamt_d = '0;
        end else if (load_s) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_wide_s[CTRL_SIZE-1:0];
            bus_a_d = rd_a_s;
            bus_b_d = rd_b_s;
            rs_d    = rs_f_s;
            rt_d    = rt_f_s;
            rd_d    = rd_f_s;
            sext_d  = {{(BUS_SIZE-16){imm_s[15]}}, imm_s};
            zext_d  = {{(BUS_SIZE-16){1'b0}}, imm_s};
            shamt_d = {{(BUS_SIZE-5){1'b0}}, shamt_f_s};
        end else begin
            valid_d = valid_q;
        end
    end

    // Register bank write port; r0 is never written.
    always_comb begin
        for (int i = 0; i < REGISTERS_BANK_SIZE; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (i_wb_write_enable && (i_wb_addr != '0)) begin
            regs_d[i_wb_addr] = i_wb_data;
        end else begin
            regs_d[0] = '0;
        end
    end

    // State, register bank and ID/EX flops.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < REGISTERS_BANK_SIZE; i++) begin
                regs_q[i] <= '0;
            end
            state_q <= ST_RUN; stall_cnt_q <= 2'd0;
            valid_q <= 1'b0; ctrl_q <= '0; bus_a_q <= '0; bus_b_q <= '0;
            rs_q <= 5'd0; rt_q <= 5'd0; rd_q <= 5'd0;
            sext_q <= '0; zext_q <= '0; shamt_q <= '0;
        end else begin
            for (int i = 0; i < REGISTERS_BANK_SIZE; i++) begin
                regs_q[i] <= regs_d[i];
            end
            state_q <= state_d; stall_cnt_q <= stall_cnt_d;
            valid_q <= valid_d; ctrl_q <= ctrl_d; bus_a_q <= bus_a_d; bus_b_q <= bus_b_d;
            rs_q <= rs_d; rt_q <= rt_d; rd_q <= rd_d;
            sext_q <= sext_d; zext_q <= zext_d; shamt_q <= shamt_d;
        end
    end

    assign o_valid            = valid_q;
    assign o_ctrl             = ctrl_q;
    assign o_bus_a            = bus_a_q;
    assign o_bus_b            = bus_b_q;
    assign o_rs               = rs_q;
    assign o_rt               = rt_q;
    assign o_rd               = rd_q;
    assign o_inm_ext_signed   = sext_q;
    assign o_inm_ext_unsigned = zext_q;
    assign o_shamt_ext        = shamt_q;

    // Flattened bank view, register i at bits [i*BUS_SIZE +: BUS_SIZE].
    always_comb begin
        o_bus_debug = '0;
        for (int i = 0; i < REGISTERS_BANK_SIZE; i++) begin
            o_bus_debug[i*BUS_SIZE +: BUS_SIZE] = regs_q[i];
        end
    end

`ifdef ID_PERF_COUNTERS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d, redirects_q, redirects_d;

    // Saturating counters; backpressure-only stalls are excluded.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        redirects_d    = redirects_q;
        if (stall_s && i_ex_ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (redirect_s && (redirects_q != 32'hFFFF_FFFF)) begin
            redirects_d = redirects_q + 32'd1;
        end else begin
            redirects_d = redirects_q;
        end
    end

    // Counter flops.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cycles_q <= 32'd0;
            redirects_q    <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            redirects_q    <= redirects_d;
        end
    end

    assign o_stall_cycles = stall_cycles_q;
    assign o_redirects    = redirects_q;
`endif

endmodule

// File: tb/tb_id_stage_hazard.sv
// Directed plan scenarios followed by randomized traffic, checked against an abstract pipeline model.
module tb_id_stage_hazard;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid, wb_we, ex_wb, ex_mr, mem_wb, ready, flush;
    logic [31:0] instr, nseq, wb_data, mem_data;
    logic [4:0]  wb_addr, ex_dst, mem_dst;

    logic        o_stall, o_redirect, o_valid;
    logic [31:0] o_redirect_pc, o_bus_a, o_bus_b, o_sext, o_zext, o_sh;
    logic [15:0] o_ctrl;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic [1023:0] o_dbg;
`ifdef ID_PERF_COUNTERS_EN
    logic [31:0] o_stall_cycles, o_redirects;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    id_stage_hazard dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_instruction(instr),
        .i_next_seq_pc(nseq), .i_wb_write_enable(wb_we), .i_wb_addr(wb_addr),
        .i_wb_data(wb_data), .i_ex_wb(ex_wb), .i_ex_mem_read(ex_mr), .i_ex_dst(ex_dst),
        .i_mem_wb(mem_wb), .i_mem_dst(mem_dst), .i_mem_data(mem_data),
        .i_ex_ready(ready), .i_flush(flush),
        .o_stall(o_stall), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
        .o_valid(o_valid), .o_ctrl(o_ctrl), .o_bus_a(o_bus_a), .o_bus_b(o_bus_b),
        .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_inm_ext_signed(o_sext), .o_inm_ext_unsigned(o_zext), .o_shamt_ext(o_sh),
`ifdef ID_PERF_COUNTERS_EN
        .o_stall_cycles(o_stall_cycles), .o_redirects(o_redirects),
`endif
        .o_bus_debug(o_dbg)
    );

    always #5 clk = ~clk;

    // Model: register file, remaining forced-stall cycles, and the expected ID/EX contents.
    logic [31:0] m_regs [32];
    int          m_left;
    logic        m_valid;
    logic [31:0] m_a, m_b, m_sext, m_zext, m_sh;
    int          m_rs, m_rt, m_rd;
    int          n_act, n_left;  // n_act: 0 hold, 1 bubble, 2 load
    logic [31:0] n_a, n_b, n_sext, n_zext, n_sh;
    int          n_rs, n_rt, n_rd;
    logic        e_stall, e_redir, s_stall, s_redir;
    logic [31:0] e_rpc, s_rpc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return 32'((rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn);
    endfunction
    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return 32'((op << 26) | (rs << 21) | (rt << 16) | (imm & 65535));
    endfunction
    function automatic logic [31:0] enc_j(int op, int dir);
        return 32'((op << 26) | (dir & 32'h03FF_FFFF));
    endfunction

    function automatic logic [31:0] rdreg(int a);
        if (a == 0) return 32'd0;
        if (wb_we && (int'(wb_addr) == a)) return wb_data;
        return m_regs[a];
    endfunction
    function automatic logic [31:0] fwdreg(int a);
        if (a != 0 && mem_wb && (int'(mem_dst) == a)) return mem_data;
        return rdreg(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_left = 0; m_valid = 1'b0;
    endtask

    task automatic model_eval();
        int op, fn, rs, rt, imm, simm, need;
        bit isbr, isjr, isj, taken;
        logic [31:0] fa, fb;
        op  = int'(instr >> 26);
        fn  = int'(instr & 32'h3F);
        rs  = int'((instr >> 21) & 32'h1F);
        rt  = int'((instr >> 16) & 32'h1F);
        imm = int'(instr & 32'hFFFF);
        simm = (imm >= 32768) ? imm - 65536 : imm;
        isbr = (op == 4) || (op == 5);
        isjr = (op == 0) && (fn == 8 || fn == 9);
        isj  = (op == 2) || (op == 3);
        fa = fwdreg(rs);
        fb = fwdreg(rt);
        taken = (op == 4 && fa == fb) || (op == 5 && fa != fb);
        need = 0;
        if (valid && ex_mr && ex_dst != 0 && (int'(ex_dst) == rs || int'(ex_dst) == rt))
            need = (isbr || isjr) ? 2 : 1;
        else if (valid && (isbr || isjr) && ex_wb && !ex_mr && ex_dst != 0 &&
                 (int'(ex_dst) == rs || (isbr && int'(ex_dst) == rt)))
            need = 1;
        if (isj) e_rpc = (nseq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
        else if (isjr) e_rpc = fa;
        else e_rpc = nseq + 32'(simm * 4);
        e_redir = 1'b0; n_left = m_left;
        if (flush) begin
            e_stall = 1'b0; n_act = 1; n_left = 0;
        end else if (!ready) begin
            e_stall = 1'b1; n_act = 0;
        end else if (m_left > 0) begin
            e_stall = 1'b1; n_act = 1; n_left = m_left - 1;
        end else if (need > 0) begin
            e_stall = 1'b1; n_act = 1; n_left = need - 1;
        end else if (valid) begin
            e_stall = 1'b0; n_act = 2; e_redir = isj || isjr || taken;
        end else begin
            e_stall = 1'b0; n_act = 1;
        end
        n_a = rdreg(rs); n_b = rdreg(rt);
        n_rs = rs; n_rt = rt; n_rd = int'((instr >> 11) & 32'h1F);
        n_sext = 32'(simm); n_zext = 32'(imm); n_sh = (instr >> 6) & 32'h1F;
    endtask

    task automatic model_commit();
        if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
        m_left = n_left;
        if (n_act == 1) m_valid = 1'b0;
        else if (n_act == 2) begin
            m_valid = 1'b1; m_a = n_a; m_b = n_b; m_rs = n_rs; m_rt = n_rt; m_rd = n_rd;
            m_sext = n_sext; m_zext = n_zext; m_sh = n_sh;
        end
    endtask

    task automatic check_regs();
        int bad;
        chk("valid", o_valid, m_valid);
        chk("ctrl_is_zero", o_ctrl == 16'h0, !m_valid);
        if (m_valid) begin
            chk("bus_a", o_bus_a, m_a);   chk("bus_b", o_bus_b, m_b);
            chk("rs", o_rs, m_rs);        chk("rt", o_rt, m_rt);   chk("rd", o_rd, m_rd);
            chk("inm_signed", o_sext, m_sext); chk("inm_unsigned", o_zext, m_zext);
            chk("shamt", o_sh, m_sh);
        end
        bad = -1;
        for (int i = 0; i < 32; i++) if (o_dbg[i*32 +: 32] !== m_regs[i] && bad < 0) bad = i;
        n_assert++;
        assert (bad < 0) else begin
            n_fail++;
            $error("FAIL bus_debug reg %0d observed=0x%0h expected=0x%0h", bad, o_dbg[bad*32 +: 32], m_regs[bad]);
        end
    endtask

    // Inputs are driven at posedge+1; combinational outputs checked at +3, registered ones at next posedge+1.
    task automatic cycle();
        #2;
        model_eval();
        s_stall = o_stall; s_redir = o_redirect; s_rpc = o_redirect_pc;
        chk("stall", o_stall, e_stall);
        chk("redirect", o_redirect, e_redir);
        if (e_redir) chk("redirect_pc", o_redirect_pc, e_rpc);
        @(posedge clk); #1;
        model_commit();
        check_regs();
    endtask

    task automatic idle();
        valid = 1'b0; instr = 32'd0; nseq = 32'h100; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        ex_wb = 1'b0; ex_mr = 1'b0; ex_dst = 5'd0; mem_wb = 1'b0; mem_dst = 5'd0; mem_data = 32'd0;
        ready = 1'b1; flush = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b1; idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("reset_valid", o_valid, 1'b0);
        chk("reset_ctrl", o_ctrl, 16'h0);
        chk("reset_bus_a", o_bus_a, 32'h0);
        chk("reset_stall", o_stall, 1'b0);
        @(posedge clk); #1;

        // write-through read
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        valid = 1'b1; instr = enc_r(5, 5, 6, 0, 32);
        cycle();
        chk("plan_wt_bus_a", o_bus_a, 32'h1234);
        chk("plan_wt_bus_b", o_bus_b, 32'h1234);

        // load-use: one stall, one bubble, then issue
        idle(); ex_mr = 1'b1; ex_dst = 5'd3; valid = 1'b1; instr = enc_r(3, 1, 4, 0, 32);
        cycle();
        chk("plan_lu_stall", s_stall, 1'b1);
        chk("plan_lu_bubble", o_valid, 1'b0);
        ex_mr = 1'b0;
        cycle();
        chk("plan_lu_nostall", s_stall, 1'b0);
        chk("plan_lu_issue", o_valid, 1'b1);
        chk("plan_lu_rs", o_rs, 5'd3);

        // load feeding a branch: two stalls, then redirect with MEM forward
        idle(); valid = 1'b1; instr = enc_i(4, 3, 0, 4); nseq = 32'h200; ex_mr = 1'b1; ex_dst = 5'd3;
        cycle();
        chk("plan_lb_stall1", s_stall, 1'b1);
        ex_mr = 1'b0; mem_wb = 1'b1; mem_dst = 5'd3; mem_data = 32'h55;
        cycle();
        chk("plan_lb_stall2", s_stall, 1'b1);
        chk("plan_lb_noredir", s_redir, 1'b0);
        mem_data = 32'h0;
        cycle();
        chk("plan_lb_redir", s_redir, 1'b1);
        chk("plan_lb_target", s_rpc, 32'h210);

        // BNE not taken with equal operands, then J target
        idle(); wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd7; cycle();
        wb_addr = 5'd2; cycle();
        idle(); valid = 1'b1; instr = enc_i(5, 1, 2, 8); cycle();
        chk("plan_bne_noredir", s_redir, 1'b0);
        instr = enc_j(2, 32'h100); nseq = 32'h1000_0004; cycle();
        chk("plan_j_redir", s_redir, 1'b1);
        chk("plan_j_target", s_rpc, 32'h1000_0400);

        // backpressure while JR sits in ID
        idle(); valid = 1'b1; instr = enc_r(1, 0, 0, 0, 8); ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("plan_bp_noredir", s_redir, 1'b0);
            chk("plan_bp_frozen", o_valid, 1'b1);
        end
        ready = 1'b1; cycle();
        chk("plan_bp_redir", s_redir, 1'b1);
        chk("plan_bp_target", s_rpc, 32'd7);

        // flush in the middle of a two-cycle stall
        idle(); valid = 1'b1; instr = enc_i(4, 3, 0, 4); ex_mr = 1'b1; ex_dst = 5'd3; cycle();
        ex_mr = 1'b0; flush = 1'b1; cycle();
        chk("plan_fl_valid", o_valid, 1'b0);
        flush = 1'b0; instr = enc_r(1, 2, 4, 0, 32); cycle();
        chk("plan_fl_run", s_stall, 1'b0);
        chk("plan_fl_issue", o_valid, 1'b1);

        // reset in the middle of a stall
        idle(); valid = 1'b1; instr = enc_i(4, 3, 0, 4); ex_mr = 1'b1; ex_dst = 5'd3; cycle();
        ex_mr = 1'b0;
        rst = 1'b1; #1;
        chk("plan_rst_valid", o_valid, 1'b0);
        chk("plan_rst_ctrl", o_ctrl, 16'h0);
        chk("plan_rst_bus_a", o_bus_a, 32'h0);
        chk("plan_rst_r1", o_dbg[63:32], 32'h0);
        chk("plan_rst_r5", o_dbg[191:160], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; idle(); model_reset();

        for (int c = 0; c < 600; c++) begin
            valid = ($urandom % 8) != 0;
            k = $urandom % 9;
            case (k)
                0: instr = enc_r($urandom % 4, $urandom % 4, $urandom % 32, $urandom % 32, 32);
                1: instr = enc_r($urandom % 4, 0, 0, 0, 8);
                2: instr = enc_r($urandom % 4, 0, $urandom % 32, 0, 9);
                3: instr = enc_i(35, $urandom % 4, $urandom % 4, $urandom % 65536);
                4: instr = enc_i(4, $urandom % 4, $urandom % 4, $urandom % 65536);
                5: instr = enc_i(5, $urandom % 4, $urandom % 4, $urandom % 65536);
                6: instr = enc_j(2, $urandom);
                7: instr = enc_j(3, $urandom);
                default: instr = enc_i(8, $urandom % 4, $urandom % 4, $urandom % 65536);
            endcase
            nseq = $urandom & 32'hFFFF_FFFC;
            wb_we = $urandom % 2; wb_addr = 5'($urandom % 4); wb_data = $urandom % 4;
            ex_wb = $urandom % 2; ex_mr = ($urandom % 4) == 0; ex_dst = 5'($urandom % 4);
            mem_wb = $urandom % 2; mem_dst = 5'($urandom % 4); mem_data = $urandom % 4;
            ready = ($urandom % 5) != 0; flush = ($urandom % 12) == 0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
